updown_cmd_scheduler: RTL and testbench

- Owns a shared WIDTH-bit up/down counter and sequences commands from NREQ requesters onto it.
- Each requester submits load / count-up / count-down-by-N commands over a valid/ready handshake.
- Round-robin arbitration grants one requester at a time; a granted command runs to completion before the next grant.
- Sits in front of the counter datapath, replacing direct drive of its inst/reset controls.

---
 rtl/updown_cmd_scheduler.sv | 139 +++++++++++++
 tb/tb_updown_cmd_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/updown_cmd_scheduler.sv
// Round-robin command scheduler in front of a shared up/down counter.
// Optional pause input enabled by defining UPDOWN_SCHED_PAUSE_EN.
module updown_cmd_scheduler #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4,
   parameter int CW    = 8
)(
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [2*NREQ-1:0]        req_op,
   input  logic [WIDTH*NREQ-1:0]    req_data,
   input  logic [CW*NREQ-1:0]       req_count,
`ifdef UPDOWN_SCHED_PAUSE_EN
   input  logic                     pause,
`endif
   output logic [NREQ-1:0]          req_ready,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   output logic                     busy,
   output logic                     done,
   output logic                     wrap,
   output logic [WIDTH-1:0]         value
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [IW-1:0]    r_ptr;
   logic [IW-1:0]    r_grantId;
   logic [WIDTH-1:0] r_value;
   logic [CW-1:0]    r_remain;
   logic             r_dirUp;
   logic             r_done;
   logic             r_wrap;

   logic             w_found;
   logic [IW-1:0]    w_winner;
   logic             w_accept;
   logic [1:0]       w_op;
   logic [WIDTH-1:0] w_data;
   logic [CW-1:0]    w_count;
   logic             w_pause;
   logic             w_step;
   logic             w_isCount;

`ifdef UPDOWN_SCHED_PAUSE_EN
   assign w_pause = pause;
`else
   assign w_pause = 1'b0;
`endif

   // Rotating search starting just past the last winner; first valid requester wins.
   always_comb begin
      int idx;
      w_found  = 1'b0;
      w_winner = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(r_ptr) + k) % NREQ;
         if (!w_found && req_valid[idx]) begin
            w_found  = 1'b1;
            w_winner = IW'(idx);
         end
      end
   end

   assign w_accept  = (r_state == IDLE) && w_found && !reset;
   assign w_op      = req_op[2*int'(w_winner) +: 2];
   assign w_data    = req_data[WIDTH*int'(w_winner) +: WIDTH];
   assign w_count   = req_count[CW*int'(w_winner) +: CW];
   assign w_isCount = (w_op == 2'b01) || (w_op == 2'b10);
   assign w_step    = (r_state == RUN) && !w_pause;

   always_comb begin
      req_ready = '0;
      req_ready[w_winner] = w_accept;
   end

   // Only counting commands with a nonzero step count occupy the RUN state.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: if (w_accept && w_isCount && (w_count != '0)) w_nextState = RUN;
         RUN:  if (w_step && (r_remain == CW'(1))) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   // Datapath: accept latches the command, each RUN step moves the counter by one.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_ptr     <= IW'(NREQ-1);
         r_grantId <= '0;
         r_value   <= '0;
         r_remain  <= '0;
         r_dirUp   <= 1'b0;
         r_done    <= 1'b0;
         r_wrap    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_ptr     <= w_winner;
            r_grantId <= w_winner;
            r_dirUp   <= (w_op == 2'b01);
            r_remain  <= w_count;
            if (w_op == 2'b11) begin
               r_value <= w_data;
               r_wrap  <= 1'b0;
            end
            if (!w_isCount || (w_count == '0)) r_done <= 1'b1;
         end
         if (w_step) begin
            r_remain <= r_remain - CW'(1);
            if (r_dirUp) begin
               r_value <= r_value + WIDTH'(1);
               if (&r_value) r_wrap <= 1'b1;
            end else begin
               r_value <= r_value - WIDTH'(1);
               if (r_value == '0) r_wrap <= 1'b1;
            end
            if (r_remain == CW'(1)) r_done <= 1'b1;
         end
      end
   end

   assign grant_id = r_grantId;
   assign busy     = (r_state == RUN);
   assign done     = r_done;
   assign wrap     = r_wrap;
   assign value    = r_value;

endmodule

// File: tb/tb_updown_cmd_scheduler.sv
// Scoreboard bench for updown_cmd_scheduler: stimulus queues expected completions,
// a monitor checks them on every done pulse; step-level values are checked inline.
module tb_updown_cmd_scheduler;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [3:0]   reqValid = '0;
   logic [7:0]   reqOp = '0;
   logic [127:0] reqData = '0;
   logic [31:0]  reqCount = '0;
   logic [3:0]   reqReady;
   logic [1:0]   grantId;
   logic         busy, done, wrap;
   logic [31:0]  value;
`ifdef UPDOWN_SCHED_PAUSE_EN
   logic         pause = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] value;
      logic        wrap;
      logic [1:0]  grant;
   } exp_t;

   exp_t expQ[$];
   logic prevDone = 1'b0;

   updown_cmd_scheduler #(.WIDTH(32), .NREQ(4), .CW(8)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (reqValid),
      .req_op    (reqOp),
      .req_data  (reqData),
      .req_count (reqCount),
`ifdef UPDOWN_SCHED_PAUSE_EN
      .pause     (pause),
`endif
      .req_ready (reqReady),
      .grant_id  (grantId),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap),
      .value     (value)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic pushExp(input logic [31:0] v, input logic w, input logic [1:0] g);
      exp_t e;
      e.value = v;
      e.wrap  = w;
      e.grant = g;
      expQ.push_back(e);
   endtask

   // Presents one command and returns just after its accepting edge.
   task automatic applyStimulus(input int id, input logic [1:0] op, input logic [31:0] data, input logic [7:0] cnt);
      bit got = 1'b0;
      @(negedge clock);
      reqValid[id]       = 1'b1;
      reqOp[2*id +: 2]   = op;
      reqData[32*id +: 32] = data;
      reqCount[8*id +: 8]  = cnt;
      for (int c = 0; c < 50 && !got; c++) begin
         #1;
         if (reqReady != 4'b0000) begin
            got = 1'b1;
            checkOutput("readyOneHot", {28'b0, reqReady}, 32'(1) << id);
         end
         @(posedge clock);
      end
      #1;
      reqValid[id] = 1'b0;
      if (!got) checkOutput("acceptTimeout", 32'd0, 32'd1);
   endtask

   // Monitor: every done pulse pops and compares one expected completion.
   always @(negedge clock) begin
      if (done) begin
         checkOutput("doneSingle", {31'b0, prevDone}, 32'd0);
         if (expQ.size() == 0) begin
            checkOutput("unexpectedDone", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("doneValue", value, e.value);
            checkOutput("doneWrap", {31'b0, wrap}, {31'b0, e.wrap});
            checkOutput("doneGrant", {30'b0, grantId}, {30'b0, e.grant});
         end
      end
      prevDone = done;
   end

   initial begin
      int order[4];
      int k;
      bit hit;

      // Reset with a requester valid: nothing may be accepted.
      reqValid[1] = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput("rstValue", value, 32'd0);
      checkOutput("rstBusy", {31'b0, busy}, 32'd0);
      checkOutput("rstDone", {31'b0, done}, 32'd0);
      checkOutput("rstWrap", {31'b0, wrap}, 32'd0);
      checkOutput("rstGrant", {30'b0, grantId}, 32'd0);
      checkOutput("rstReady", {28'b0, reqReady}, 32'd0);
      reqValid[1] = 1'b0;
      @(posedge clock); #1 reset = 1'b0;

      $display("[TB] load 0x10 from requester 0");
      pushExp(32'h10, 1'b0, 2'd0);
      applyStimulus(0, 2'b11, 32'h10, 8'd0);
      @(negedge clock);
      checkOutput("loadDoneNext", {31'b0, done}, 32'd1);

      $display("[TB] down by 3 from requester 2");
      pushExp(32'hD, 1'b0, 2'd2);
      applyStimulus(2, 2'b10, 32'h0, 8'd3);
      @(negedge clock);
      checkOutput("downBusy0", {31'b0, busy}, 32'd1);
      checkOutput("downVal0", value, 32'h10);
      @(negedge clock);
      checkOutput("downVal1", value, 32'hF);
      @(negedge clock);
      checkOutput("downVal2", value, 32'hE);
      checkOutput("downBusy2", {31'b0, busy}, 32'd1);
      @(negedge clock);
      checkOutput("downVal3", value, 32'hD);
      checkOutput("downBusyEnd", {31'b0, busy}, 32'd0);
      checkOutput("downDone", {31'b0, done}, 32'd1);

      $display("[TB] wrap on up from all-ones");
      pushExp(32'hFFFF_FFFF, 1'b0, 2'd1);
      applyStimulus(1, 2'b11, 32'hFFFF_FFFF, 8'd0);
      pushExp(32'h1, 1'b1, 2'd1);
      applyStimulus(1, 2'b01, 32'h0, 8'd2);
      @(negedge clock);
      checkOutput("wrapPre", {31'b0, wrap}, 32'd0);
      @(negedge clock);
      checkOutput("wrapVal1", value, 32'h0);
      checkOutput("wrapSet", {31'b0, wrap}, 32'd1);
      @(negedge clock);
      checkOutput("wrapHeld", {31'b0, wrap}, 32'd1);
      pushExp(32'h5, 1'b0, 2'd1);
      applyStimulus(1, 2'b11, 32'h5, 8'd0);
      @(negedge clock);
      checkOutput("wrapCleared", {31'b0, wrap}, 32'd0);

      $display("[TB] reset during a 200-step count");
      applyStimulus(3, 2'b01, 32'h0, 8'd200);
      hit = 1'b0;
      for (int c = 0; c < 300 && !hit; c++) begin
         @(negedge clock);
         if (value == 32'd54) hit = 1'b1;
      end
      if (!hit) checkOutput("midRunTimeout", 32'd0, 32'd1);
      reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      @(negedge clock);
      checkOutput("abortValue", value, 32'd0);
      checkOutput("abortBusy", {31'b0, busy}, 32'd0);
      checkOutput("abortGrant", {30'b0, grantId}, 32'd0);

      $display("[TB] round robin among requesters 0,1,3");
      order = '{0, 1, 3, 0};
      pushExp(32'd1, 1'b0, 2'd0);
      pushExp(32'd2, 1'b0, 2'd1);
      pushExp(32'd3, 1'b0, 2'd3);
      pushExp(32'd4, 1'b0, 2'd0);
      for (int i = 0; i < 4; i++) begin
         reqOp[2*i +: 2]  = 2'b01;
         reqCount[8*i +: 8] = 8'd1;
      end
      reqValid = 4'b1011;
      k = 0;
      for (int c = 0; c < 40 && k < 4; c++) begin
         #1;
         if (reqReady != 4'b0000) begin
            checkOutput("rrOrder", {28'b0, reqReady}, 32'(1) << order[k]);
            k++;
            if (k == 4) begin
               @(posedge clock); #1 reqValid = 4'b0000;
            end
         end
         if (k < 4) @(posedge clock);
      end
      if (k != 4) checkOutput("rrTimeout", k, 32'd4);
      reqValid = 4'b0000;
      repeat (3) @(negedge clock);
      checkOutput("rrFinal", value, 32'd4);

`ifdef UPDOWN_SCHED_PAUSE_EN
      $display("[TB] pause during up by 4");
      pushExp(32'd0, 1'b0, 2'd2);
      applyStimulus(2, 2'b11, 32'h0, 8'd0);
      pushExp(32'd4, 1'b0, 2'd2);
      applyStimulus(2, 2'b01, 32'h0, 8'd4);
      @(posedge clock); #1 pause = 1'b1;
      @(negedge clock);
      checkOutput("pauseVal1", value, 32'd1);
      @(negedge clock);
      checkOutput("pauseVal2", value, 32'd1);
      checkOutput("pauseBusy", {31'b0, busy}, 32'd1);
      @(posedge clock); #1 pause = 1'b0;
      @(negedge clock);
      checkOutput("pauseVal3", value, 32'd1);
      @(negedge clock);
      checkOutput("pauseVal4", value, 32'd2);
      @(negedge clock);
      checkOutput("pauseVal5", value, 32'd3);
      @(negedge clock);
      checkOutput("pauseVal6", value, 32'd4);
      checkOutput("pauseDone", {31'b0, done}, 32'd1);
`endif

      repeat (4) @(negedge clock);
      checkOutput("queueEmpty", expQ.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
